ex_stage: RTL and testbench

- Execute stage of the DLX pipeline, directly upstream of the memory stage; consumes ID/EX operands and produces the EX/MEM pipeline registers (ALU result, memory enables, store register, destination).
- Single-cycle ALU ops, plus a 32-cycle iterative unsigned multiply/divide unit that stalls the front of the pipe.
- Operand forwarding from the MEM and WB stages.

---
 rtl/dlx_pkg.sv | 38 +++
 rtl/muldiv_iter.sv | 105 ++++++++++
 rtl/ex_stage.sv | 131 +++++++++++++
 tb/tb_ex_stage.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlx_pkg.sv
// Shared DLX execute-stage definitions: ALU opcodes, FSM states and datapath sizing.
package dlx_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned MD_CYCLES = 32;
    localparam int unsigned OP_W      = 5;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned SHAMT_W   = $clog2(XLEN);
    localparam int unsigned CNT_W     = $clog2(MD_CYCLES);

    typedef enum logic [OP_W-1:0] {
        ALU_ADD   = 5'd0,
        ALU_SUB   = 5'd1,
        ALU_AND   = 5'd2,
        ALU_OR    = 5'd3,
        ALU_XOR   = 5'd4,
        ALU_SLL   = 5'd5,
        ALU_SRL   = 5'd6,
        ALU_SRA   = 5'd7,
        ALU_SLT   = 5'd8,
        ALU_SLTU  = 5'd9,
        ALU_SEQ   = 5'd10,
        ALU_SNE   = 5'd11,
        ALU_LHI   = 5'd12,
        ALU_MULTU = 5'd13,
        ALU_DIVU  = 5'd14
    } alu_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ex_state_t;

    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return (op == ALU_MULTU) || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) engine, one step per clock.
module muldiv_iter
    import dlx_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [OP_W-1:0]      op,
    input  logic [XLEN-1:0]      a,
    input  logic [XLEN-1:0]      b,
    input  logic                 flush,
    output logic                 busy,
    output logic                 last,
    output logic [XLEN-1:0]      result
);

    ex_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    // acc: product or partial remainder; x: multiplicand or dividend/quotient; y: multiplier or divisor
    logic [XLEN-1:0]  acc_q, acc_d;
    logic [XLEN-1:0]  x_q, x_d;
    logic [XLEN-1:0]  y_q, y_d;

    logic [XLEN:0]    rem_shift;
    logic [XLEN:0]    trial;
    logic             fits;
    logic [XLEN-1:0]  step_acc, step_x, step_y;

    assign busy   = (state_q == BUSY);
    assign last   = busy && (cnt_q == CNT_W'(MD_CYCLES - 1));
    assign result = is_div_q ? step_x : step_acc;

    // One iteration of the selected algorithm; with a zero divisor every bit fits, giving all ones.
    always_comb begin
        rem_shift = {acc_q, x_q[XLEN-1]};
        trial     = rem_shift - {1'b0, y_q};
        fits      = (rem_shift >= {1'b0, y_q});
        step_acc  = acc_q;
        step_x    = x_q;
        step_y    = y_q;
        if (is_div_q) begin
            step_acc = fits ? trial[XLEN-1:0] : rem_shift[XLEN-1:0];
            step_x   = {x_q[XLEN-2:0], fits};
        end else begin
            step_acc = acc_q + (y_q[0] ? x_q : '0);
            step_x   = {x_q[XLEN-2:0], 1'b0};
            step_y   = {1'b0, y_q[XLEN-1:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        acc_d    = acc_q;
        x_d      = x_q;
        y_d      = y_q;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    state_d  = BUSY;
                    cnt_d    = '0;
                    is_div_d = (op == ALU_DIVU);
                    acc_d    = '0;
                    x_d      = a;
                    y_d      = b;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = step_acc;
                    x_d   = step_x;
                    y_d   = step_y;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            acc_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// DLX execute stage: operand forwarding, single-cycle ALU, multi-cycle mul/div stall and EX/MEM registers.
module ex_stage
    import dlx_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OP_W-1:0]      alu_op_EX,
    input  logic [XLEN-1:0]      S1_EX,
    input  logic [XLEN-1:0]      S2_EX,
    input  logic [XLEN-1:0]      Imm_EX,
    input  logic                 use_imm_EX,
    input  logic [REG_W-1:0]     Rs1_EX,
    input  logic [REG_W-1:0]     Rs2_EX,
    input  logic [REG_W-1:0]     Rd_EX,
    input  logic                 d_write_enable_EX,
    input  logic                 d_load_enable_EX,
    input  logic                 flush_EX,
    input  logic [XLEN-1:0]      ALU_out_MEM_backward,
    input  logic [REG_W-1:0]     Rd_MEM_backward,
    input  logic [REG_W-1:0]     Rd_WB_backward,
    input  logic [XLEN-1:0]      Data_WB_backward,
    output logic                 stall_EX,
    output logic [XLEN-1:0]      ALU_out_MEM,
    output logic                 d_write_enable_MEM,
    output logic                 d_load_enable_MEM,
    output logic [REG_W-1:0]     Rs2_MEM,
    output logic [REG_W-1:0]     Rd_MEM
);

    logic [XLEN-1:0]  op_a, s2_fwd, op_b;
    logic [XLEN-1:0]  alu_res;
    logic             md_start, md_busy, md_last;
    logic [XLEN-1:0]  md_result;

    logic [XLEN-1:0]  alu_out_d;
    logic             we_d, le_d;
    logic [REG_W-1:0] rs2_d, rd_d;

    // MEM beats WB; register 0 never forwards.
    function automatic logic [XLEN-1:0] fwd(input logic [REG_W-1:0] rs,
                                            input logic [XLEN-1:0]  reg_val);
        if (rs != '0 && rs == Rd_MEM_backward) return ALU_out_MEM_backward;
        if (rs != '0 && rs == Rd_WB_backward)  return Data_WB_backward;
        return reg_val;
    endfunction

    assign op_a   = fwd(Rs1_EX, S1_EX);
    assign s2_fwd = fwd(Rs2_EX, S2_EX);
    assign op_b   = use_imm_EX ? Imm_EX : s2_fwd;

    always_comb begin
        alu_res = '0;
        case (alu_op_t'(alu_op_EX))
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SLL:  alu_res = op_a << op_b[SHAMT_W-1:0];
            ALU_SRL:  alu_res = op_a >> op_b[SHAMT_W-1:0];
            ALU_SRA:  alu_res = XLEN'($signed(op_a) >>> op_b[SHAMT_W-1:0]);
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_SEQ:  alu_res = {{(XLEN-1){1'b0}}, (op_a == op_b)};
            ALU_SNE:  alu_res = {{(XLEN-1){1'b0}}, (op_a != op_b)};
            ALU_LHI:  alu_res = {op_b[15:0], 16'h0};
            default:  alu_res = '0;
        endcase
    end

    assign md_start = is_muldiv(alu_op_EX) && !flush_EX && !md_busy;

    muldiv_iter u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start),
        .op     (alu_op_EX),
        .a      (op_a),
        .b      (op_b),
        .flush  (flush_EX),
        .busy   (md_busy),
        .last   (md_last),
        .result (md_result)
    );

    // Held low during reset so an abandoned operation does not keep the front end frozen.
    assign stall_EX = !reset && (md_start || (md_busy && !md_last && !flush_EX));

    // EX/MEM next values; anything not explicitly retired is a bubble.
    always_comb begin
        alu_out_d = '0;
        we_d      = 1'b0;
        le_d      = 1'b0;
        rs2_d     = '0;
        rd_d      = '0;
        if (!flush_EX) begin
            if (md_busy) begin
                if (md_last) begin
                    alu_out_d = md_result;
                    we_d      = d_write_enable_EX;
                    le_d      = d_load_enable_EX;
                    rs2_d     = Rs2_EX;
                    rd_d      = Rd_EX;
                end
            end else if (!is_muldiv(alu_op_EX)) begin
                alu_out_d = alu_res;
                we_d      = d_write_enable_EX;
                le_d      = d_load_enable_EX;
                rs2_d     = Rs2_EX;
                rd_d      = Rd_EX;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ALU_out_MEM        <= '0;
            d_write_enable_MEM <= 1'b0;
            d_load_enable_MEM  <= 1'b0;
            Rs2_MEM            <= '0;
            Rd_MEM             <= '0;
        end else begin
            ALU_out_MEM        <= alu_out_d;
            d_write_enable_MEM <= we_d;
            d_load_enable_MEM  <= le_d;
            Rs2_MEM            <= rs2_d;
            Rd_MEM             <= rd_d;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, random ALU traffic and mul/div sequences.
module tb_ex_stage;
    import dlx_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  alu_op_EX;
    logic [31:0] S1_EX, S2_EX, Imm_EX;
    logic        use_imm_EX;
    logic [4:0]  Rs1_EX, Rs2_EX, Rd_EX;
    logic        d_write_enable_EX, d_load_enable_EX, flush_EX;
    logic [31:0] ALU_out_MEM_backward, Data_WB_backward;
    logic [4:0]  Rd_MEM_backward, Rd_WB_backward;
    logic        stall_EX;
    logic [31:0] ALU_out_MEM;
    logic        d_write_enable_MEM, d_load_enable_MEM;
    logic [4:0]  Rs2_MEM, Rd_MEM;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk                  (clk),
        .reset                (reset),
        .alu_op_EX            (alu_op_EX),
        .S1_EX                (S1_EX),
        .S2_EX                (S2_EX),
        .Imm_EX               (Imm_EX),
        .use_imm_EX           (use_imm_EX),
        .Rs1_EX               (Rs1_EX),
        .Rs2_EX               (Rs2_EX),
        .Rd_EX                (Rd_EX),
        .d_write_enable_EX    (d_write_enable_EX),
        .d_load_enable_EX     (d_load_enable_EX),
        .flush_EX             (flush_EX),
        .ALU_out_MEM_backward (ALU_out_MEM_backward),
        .Rd_MEM_backward      (Rd_MEM_backward),
        .Rd_WB_backward       (Rd_WB_backward),
        .Data_WB_backward     (Data_WB_backward),
        .stall_EX             (stall_EX),
        .ALU_out_MEM          (ALU_out_MEM),
        .d_write_enable_MEM   (d_write_enable_MEM),
        .d_load_enable_MEM    (d_load_enable_MEM),
        .Rs2_MEM              (Rs2_MEM),
        .Rd_MEM               (Rd_MEM)
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] s1, s2, imm;
        logic        use_imm;
        logic [4:0]  rs1, rs2, rd;
        logic        we, le;
        logic [4:0]  rdm;
        logic [31:0] alum;
        logic [4:0]  rdw;
        logic [31:0] datw;
        logic [31:0] exp_alu;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference semantics from the instruction definitions, using wide arithmetic.
    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] wide;
        case (op)
            ALU_ADD:   return a + b;
            ALU_SUB:   return a - b;
            ALU_AND:   return a & b;
            ALU_OR:    return a | b;
            ALU_XOR:   return a ^ b;
            ALU_SLL:   return a << b[4:0];
            ALU_SRL:   return a >> b[4:0];
            ALU_SRA: begin
                wide = {{32{a[31]}}, a} >> b[4:0];
                return wide[31:0];
            end
            ALU_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            ALU_SEQ:   return (a == b) ? 32'd1 : 32'd0;
            ALU_SNE:   return (a != b) ? 32'd1 : 32'd0;
            ALU_LHI:   return {16'h0, b[15:0]} * 32'h10000;
            ALU_MULTU: begin
                wide = 64'(a) * 64'(b);
                return wide[31:0];
            end
            ALU_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default:   return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] v,
                                            input logic [4:0] rdm, input logic [31:0] alum,
                                            input logic [4:0] rdw, input logic [31:0] datw);
        if (rs != 0 && rs == rdm) return alum;
        if (rs != 0 && rs == rdw) return datw;
        return v;
    endfunction

    function automatic vec_t mkv(input logic [4:0] op, input logic [31:0] s1, input logic [31:0] s2,
                                 input logic [31:0] imm, input logic use_imm,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic we, input logic le,
                                 input logic [4:0] rdm, input logic [31:0] alum,
                                 input logic [4:0] rdw, input logic [31:0] datw,
                                 input logic [31:0] exp_alu);
        vec_t v;
        v.op = op; v.s1 = s1; v.s2 = s2; v.imm = imm; v.use_imm = use_imm;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.we = we; v.le = le;
        v.rdm = rdm; v.alum = alum; v.rdw = rdw; v.datw = datw; v.exp_alu = exp_alu;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        alu_op_EX = v.op; S1_EX = v.s1; S2_EX = v.s2; Imm_EX = v.imm; use_imm_EX = v.use_imm;
        Rs1_EX = v.rs1; Rs2_EX = v.rs2; Rd_EX = v.rd;
        d_write_enable_EX = v.we; d_load_enable_EX = v.le;
        Rd_MEM_backward = v.rdm; ALU_out_MEM_backward = v.alum;
        Rd_WB_backward = v.rdw; Data_WB_backward = v.datw;
    endtask

    // One single-cycle instruction through EX, checking every EX/MEM field.
    task automatic apply_check(input string name, input vec_t v);
        drive(v);
        #1;
        chk({name, "_stall"}, 32'(stall_EX), 32'd0);
        @(posedge clk); #1;
        chk({name, "_alu"}, ALU_out_MEM, v.exp_alu);
        chk({name, "_rd"}, 32'(Rd_MEM), 32'(v.rd));
        chk({name, "_rs2"}, 32'(Rs2_MEM), 32'(v.rs2));
        chk({name, "_we"}, 32'(d_write_enable_MEM), 32'(v.we));
        chk({name, "_le"}, 32'(d_load_enable_MEM), 32'(v.le));
    endtask

    // Multiply/divide through EX; flush_at is the stall-cycle index at which to flush (-1: none).
    task automatic run_md(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input int flush_at);
        int  stalls;
        bit  flushed;
        vec_t v;
        v = mkv(op, a, b, 32'h0, 1'b0, 5'd1, 5'd2, rd, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0);
        drive(v);
        flush_EX = 1'b0;
        stalls = 0;
        flushed = 0;
        #1;
        while (stall_EX && stalls < 40) begin
            if (stalls == flush_at) begin
                flush_EX = 1'b1;
                #1;
                chk({name, "_flush_stall_drop"}, 32'(stall_EX), 32'd0);
                flushed = 1;
                break;
            end
            @(posedge clk); #1;
            stalls++;
            chk({name, "_bubble_rd"}, 32'(Rd_MEM), 32'd0);
        end
        chk({name, "_stall_cycles"}, 32'(stalls), (flush_at >= 0) ? 32'(flush_at) : 32'd32);
        @(posedge clk); #1;
        if (flushed) begin
            chk({name, "_flush_rd"}, 32'(Rd_MEM), 32'd0);
            chk({name, "_flush_alu"}, ALU_out_MEM, 32'd0);
            chk({name, "_flush_we"}, 32'(d_write_enable_MEM), 32'd0);
            flush_EX = 1'b0;
        end else begin
            chk({name, "_result"}, ALU_out_MEM, ref_alu(op, a, b));
            chk({name, "_rd"}, 32'(Rd_MEM), 32'(rd));
        end
        alu_op_EX = ALU_ADD;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[13];
        vec_t rv;
        logic [4:0] ops[13];
        vec_t v;

        vecs[0]  = mkv(ALU_ADD, 32'd2, 32'd3, 32'd0, 0, 5'd1, 5'd2, 5'd3, 0, 0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd5);
        vecs[1]  = mkv(ALU_ADD, 32'd9, 32'd1, 32'd0, 0, 5'd4, 5'd5, 5'd6, 0, 0, 5'd4, 32'd100, 5'd4, 32'd7, 32'd101);
        vecs[2]  = mkv(ALU_ADD, 32'd9, 32'd1, 32'd0, 0, 5'd0, 5'd5, 5'd6, 0, 0, 5'd0, 32'd100, 5'd0, 32'd7, 32'd10);
        vecs[3]  = mkv(ALU_ADD, 32'd9, 32'd1, 32'd0, 0, 5'd4, 5'd5, 5'd6, 0, 0, 5'd6, 32'd100, 5'd4, 32'd7, 32'd8);
        vecs[4]  = mkv(ALU_ADD, 32'h1000, 32'd55, 32'hFFFF_FFFC, 1, 5'd1, 5'd7, 5'd0, 1, 0, 5'd0, 32'd0, 5'd0, 32'd0, 32'h0000_0FFC);
        vecs[5]  = mkv(ALU_LHI, 32'd0, 32'd0, 32'h0000_ABCD, 1, 5'd0, 5'd0, 5'd8, 0, 0, 5'd0, 32'd0, 5'd0, 32'd0, 32'hABCD_0000);
        vecs[6]  = mkv(ALU_SRA, 32'h8000_0000, 32'd4, 32'd0, 0, 5'd1, 5'd2, 5'd9, 0, 0, 5'd0, 32'd0, 5'd0, 32'd0, 32'hF800_0000);
        vecs[7]  = mkv(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 5'd1, 5'd2, 5'd9, 0, 0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd1);
        vecs[8]  = mkv(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 5'd1, 5'd2, 5'd9, 0, 0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0);
        vecs[9]  = mkv(ALU_SUB, 32'd3, 32'd5, 32'd0, 0, 5'd1, 5'd2, 5'd10, 0, 1, 5'd0, 32'd0, 5'd0, 32'd0, 32'hFFFF_FFFE);
        vecs[10] = mkv(ALU_SEQ, 32'd5, 32'd5, 32'd0, 0, 5'd1, 5'd2, 5'd11, 0, 0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd1);
        vecs[11] = mkv(ALU_SNE, 32'd5, 32'd5, 32'd0, 0, 5'd1, 5'd2, 5'd11, 0, 0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0);
        vecs[12] = mkv(ALU_SLL, 32'd1, 32'd99, 32'd0, 0, 5'd1, 5'd3, 5'd12, 0, 0, 5'd3, 32'h10, 5'd0, 32'd0, 32'h0001_0000);

        ops = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL,
                ALU_SRA, ALU_SLT, ALU_SLTU, ALU_SEQ, ALU_SNE, ALU_LHI};

        reset = 1'b1;
        flush_EX = 1'b0;
        drive(vecs[0]);
        #1;
        chk("reset_alu", ALU_out_MEM, 32'd0);
        chk("reset_rd", 32'(Rd_MEM), 32'd0);
        chk("reset_we", 32'(d_write_enable_MEM), 32'd0);
        chk("reset_stall", 32'(stall_EX), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) apply_check($sformatf("vec%0d", i), vecs[i]);

        // Random single-cycle traffic with small register indices so forwarding paths collide.
        for (int i = 0; i < 200; i++) begin
            rv.op = ops[$urandom_range(0, 12)];
            rv.s1 = $urandom; rv.s2 = $urandom; rv.imm = $urandom;
            rv.use_imm = 1'($urandom_range(0, 1));
            rv.rs1 = 5'($urandom_range(0, 5)); rv.rs2 = 5'($urandom_range(0, 5));
            rv.rd = 5'($urandom_range(0, 31));
            rv.we = 1'($urandom_range(0, 1)); rv.le = 1'($urandom_range(0, 1));
            rv.rdm = 5'($urandom_range(0, 5)); rv.alum = $urandom;
            rv.rdw = 5'($urandom_range(0, 5)); rv.datw = $urandom;
            if ($urandom_range(0, 3) == 0) rv.s2 = 32'($urandom_range(0, 40));
            rv.exp_alu = ref_alu(rv.op,
                                 ref_fwd(rv.rs1, rv.s1, rv.rdm, rv.alum, rv.rdw, rv.datw),
                                 rv.use_imm ? rv.imm
                                            : ref_fwd(rv.rs2, rv.s2, rv.rdm, rv.alum, rv.rdw, rv.datw));
            if ($urandom_range(0, 7) == 0) begin
                drive(rv);
                flush_EX = 1'b1;
                @(posedge clk); #1;
                chk("rand_flush_rd", 32'(Rd_MEM), 32'd0);
                chk("rand_flush_alu", ALU_out_MEM, 32'd0);
                chk("rand_flush_en", 32'({d_write_enable_MEM, d_load_enable_MEM}), 32'd0);
                flush_EX = 1'b0;
            end else begin
                apply_check("rand", rv);
            end
        end

        run_md("multu", ALU_MULTU, 32'h0001_0003, 32'h0002_0005, 5'd7, -1);
        run_md("divu", ALU_DIVU, 32'd100, 32'd7, 5'd8, -1);
        run_md("divu0", ALU_DIVU, 32'd5, 32'd0, 5'd9, -1);
        run_md("divu_big", ALU_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd10, -1);
        run_md("multu_flush", ALU_MULTU, 32'h0001_0003, 32'h0002_0005, 5'd11, 16);
        apply_check("after_flush_add", vecs[0]);
        for (int i = 0; i < 4; i++) begin
            run_md("rand_md", (i % 2 == 0) ? ALU_MULTU : ALU_DIVU, $urandom,
                   (i == 3) ? 32'($urandom_range(1, 1000)) : $urandom, 5'($urandom_range(1, 31)), -1);
        end

        // Reset in the middle of a divide.
        v = mkv(ALU_DIVU, 32'd100, 32'd7, 32'd0, 0, 5'd1, 5'd2, 5'd5, 0, 0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0);
        drive(v);
        repeat (10) @(posedge clk);
        #1;
        chk("rst_mid_stall_before", 32'(stall_EX), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_alu", ALU_out_MEM, 32'd0);
        chk("rst_mid_rd", 32'(Rd_MEM), 32'd0);
        chk("rst_mid_en", 32'({d_write_enable_MEM, d_load_enable_MEM, Rs2_MEM}), 32'd0);
        chk("rst_mid_stall", 32'(stall_EX), 32'd0);
        drive(vecs[0]);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        apply_check("post_reset_add", vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
